// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// frame constants, state encoding and the frame-length legality rule.
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         LEN_W         = 16;

    // Loader state encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LEN_HI = 3'd1;
    localparam state_t S_LEN_LO = 3'd2;
    localparam state_t S_DATA   = 3'd3;
    localparam state_t S_WRITE  = 3'd4;
    localparam state_t S_CSUM   = 3'd5;
    localparam state_t S_DONE   = 3'd6;
    localparam state_t S_ERR    = 3'd7;

    // A frame may carry 1 .. 2^addr_w words; 2^addr_w fills the memory exactly.
    function automatic logic len_valid(input logic [LEN_W-1:0] n,
                                       input int unsigned      addr_w);
        return (n != '0) && ({16'd0, n} <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// master = byte source / memory side, slave = loader side.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted payload bytes MSB-first into 32-bit words and keeps a
// running XOR of every payload byte seen since the last clear.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full,
    output logic [7:0]  csum
);

    logic [1:0]  byte_idx;
    logic [31:0] word_q;
    logic [7:0]  csum_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx <= '0;
            word_q   <= '0;
            csum_q   <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word_q   <= '0;
            csum_q   <= '0;
        end else if (byte_en) begin
            byte_idx <= byte_idx + 2'd1;
            word_q   <= {word_q[23:0], byte_in};
            csum_q   <= csum_q ^ byte_in;
        end
    end

    // High while the byte being accepted is the last one of a word.
    assign word_full = byte_en && (byte_idx == 2'd3);
    assign word      = word_q;
    assign csum      = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-serial loader: parses SYNC/LEN/payload/CSUM, writes words to
// instruction memory from address 0 and releases the CPU only on a clean load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic         ref_clk,
    input  logic         reset,
    imem_loader_if.slave bus,
    output logic         cpu_run,
    output logic         load_done,
    output logic         load_err
);

    state_t            state;
    state_t            next_state;
    logic              in_ready_q;
    logic              accept;
    logic [7:0]        len_hi;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  frame_len;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   word_cnt_next;
    logic              last_word;
    logic              is_sync;

    logic              asm_clear;
    logic              asm_byte_en;
    logic              asm_full;
    logic [31:0]       asm_word;
    logic [7:0]        asm_csum;

    assign accept        = bus.in_valid && in_ready_q;
    assign is_sync       = (bus.in_data == SYNC_BYTE);
    assign frame_len     = {len_hi, bus.in_data};
    assign word_cnt_next = word_cnt + (ADDR_W+1)'(1);
    assign last_word     = (LEN_W'(word_cnt_next) == len);

    assign asm_clear   = (state == S_LEN_LO) && accept;
    assign asm_byte_en = (state == S_DATA) && accept;

    word_assembler u_asm (
        .clk       (ref_clk),
        .rst_n     (reset),
        .clear     (asm_clear),
        .byte_en   (asm_byte_en),
        .byte_in   (bus.in_data),
        .word      (asm_word),
        .word_full (asm_full),
        .csum      (asm_csum)
    );

    always_comb begin
        // NOTE: next_state gets a default before the case so no path leaves
        // it unassigned, which would infer a latch.
        next_state = state;
        case (state)
            S_IDLE:   if (accept && is_sync) next_state = S_LEN_HI;
            S_LEN_HI: if (accept) next_state = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    next_state = len_valid(frame_len, ADDR_W) ? S_DATA : S_ERR;
                end
            end
            S_DATA:   if (asm_full) next_state = S_WRITE;
            S_WRITE:  next_state = last_word ? S_CSUM : S_DATA;
            S_CSUM: begin
                if (accept) begin
                    next_state = (bus.in_data == asm_csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE,
            S_ERR:    if (accept && is_sync) next_state = S_LEN_HI;
            default:  next_state = S_IDLE;
        endcase
    end

    // NOTE: reset clears control state only; the instruction memory keeps
    // whatever an aborted load already wrote.
    always_ff @(posedge ref_clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            in_ready_q <= 1'b0;
            len_hi     <= '0;
            len        <= '0;
            addr       <= '0;
            word_cnt   <= '0;
        end else begin
            state      <= next_state;
            // Registered ready: only the WRITE bubble refuses a byte.
            in_ready_q <= (next_state != S_WRITE);
            if ((state == S_LEN_HI) && accept) begin
                len_hi <= bus.in_data;
            end
            if ((state == S_LEN_LO) && accept) begin
                len      <= frame_len;
                addr     <= '0;
                word_cnt <= '0;
            end
            // The address wraps after the 2^ADDR_W-th write; nothing reads it then.
            if (state == S_WRITE) begin
                addr     <= addr + ADDR_W'(1);
                word_cnt <= word_cnt_next;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = (state == S_WRITE);
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = asm_word;

    assign cpu_run   = (state == S_DONE);
    assign load_done = (state == S_DONE);
    assign load_err  = (state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frame table, hand-written
// timing/reset/reload sequences and random streams against a frame parser model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W = 8;
    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic ref_clk = 1'b0;
    logic reset   = 1'b0;
    logic cpu_run, load_done, load_err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       name;
        int          nb;
        logic [7:0]  b [12];
        int          nw;
        logic [31:0] w [2];
        logic        done;
        logic        err;
    } vec_t;

    wr_t        got_q [$];
    wr_t        exp_q [$];
    logic [7:0] stream_q [$];
    int         n_checks  = 0;
    int         n_pass    = 0;
    int         stall_cnt = 0;

    // Every write strobe seen on the memory port, in order.
    always @(negedge ref_clk) begin
        if (bus.imem_we === 1'b1) got_q.push_back({bus.imem_addr, bus.imem_wdata});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge ref_clk);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge ref_clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_imem_we", bus.imem_we, 0);
        check("rst_imem_addr", bus.imem_addr, 0);
        check("rst_imem_wdata", bus.imem_wdata, 0);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_err", load_err, 0);
        reset = 1'b1;
        @(negedge ref_clk);
        check("rst_release_in_ready", bus.in_ready, 1);
    endtask

    // Returns at the first falling edge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int wait_cyc;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(negedge ref_clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        wait_cyc     = 0;
        while (bus.in_ready !== 1'b1 && wait_cyc < 20) begin
            stall_cnt++;
            @(negedge ref_clk);
            wait_cyc++;
        end
        if (bus.in_ready !== 1'b1) check("in_ready_timeout", bus.in_ready, 1);
        else @(negedge ref_clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input int gap_max);
        foreach (stream_q[i]) send_byte(stream_q[i], $urandom_range(0, gap_max));
    endtask

    task automatic send_nominal();
        logic [7:0] f [12];
        f = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h00, 8'h00, 8'h00, 8'h01, 8'h23};
        foreach (f[i]) send_byte(f[i], 0);
    endtask

    // Frame parser: drops bytes until SYNC, then LEN, N words, XOR checksum.
    function automatic int ref_model();
        int         st;
        int         i;
        int         n;
        logic [7:0] cs;
        logic [31:0] w;
        st = M_IDLE;
        i  = 0;
        exp_q.delete();
        while (i < stream_q.size()) begin
            if (stream_q[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            st = M_BUSY;
            if (i + 2 > stream_q.size()) break;
            n = int'({stream_q[i], stream_q[i+1]});
            i += 2;
            if (n == 0 || n > (1 << ADDR_W)) begin
                st = M_ERR;
                continue;
            end
            cs = 8'h00;
            for (int k = 0; k < n; k++) begin
                if (i + 4 > stream_q.size()) return M_BUSY;
                w  = {stream_q[i], stream_q[i+1], stream_q[i+2], stream_q[i+3]};
                cs = cs ^ stream_q[i] ^ stream_q[i+1] ^ stream_q[i+2] ^ stream_q[i+3];
                exp_q.push_back({8'(k), w});
                i += 4;
            end
            if (i >= stream_q.size()) return M_BUSY;
            st = (stream_q[i] == cs) ? M_DONE : M_ERR;
            i++;
        end
        return st;
    endfunction

    task automatic check_status(input string name, input int st);
        check({name, "_load_done"}, load_done, st == M_DONE);
        check({name, "_load_err"}, load_err, st == M_ERR);
        check({name, "_cpu_run"}, cpu_run, st == M_DONE);
    endtask

    task automatic compare_writes(input string name);
        check({name, "_wr_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_wr%0d", name, i), got_q[i], exp_q[i]);
    endtask

    logic [7:0] rb;
    int         st;
    vec_t       vecs [6];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        vecs[0] = '{"nominal", 12, '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                    8'h00, 8'h00, 8'h00, 8'h01, 8'h23}, 2, '{32'hDEADBEEF, 32'h00000001}, 1'b1, 1'b0};
        vecs[1] = '{"bad_csum", 12, '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                    8'h00, 8'h00, 8'h00, 8'h01, 8'h24}, 2, '{32'hDEADBEEF, 32'h00000001}, 1'b0, 1'b1};
        vecs[2] = '{"len_zero", 3, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, '{32'h0, 32'h0}, 1'b0, 1'b1};
        vecs[3] = '{"len_257", 3, '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, '{32'h0, 32'h0}, 1'b0, 1'b1};
        vecs[4] = '{"junk_first", 10, '{8'h00, 8'h11, 8'hA5, 8'h00, 8'h01, 8'h12, 8'h34,
                    8'h56, 8'h78, 8'h08, 8'h00, 8'h00}, 1, '{32'h12345678, 32'h0}, 1'b1, 1'b0};
        vecs[5] = '{"sync_payload", 8, '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, '{32'hA5A5A5A5, 32'h0}, 1'b1, 1'b0};

        // Directed frame table; status is checked at the edge right after the last byte.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            got_q.delete();
            for (int j = 0; j < vecs[v].nb; j++) send_byte(vecs[v].b[j], 0);
            check({vecs[v].name, "_load_done"}, load_done, vecs[v].done);
            check({vecs[v].name, "_load_err"}, load_err, vecs[v].err);
            check({vecs[v].name, "_cpu_run"}, cpu_run, vecs[v].done);
            idle(3);
            check({vecs[v].name, "_wr_count"}, got_q.size(), vecs[v].nw);
            for (int j = 0; j < vecs[v].nw && j < got_q.size(); j++) begin
                check($sformatf("%s_addr%0d", vecs[v].name, j), got_q[j].addr, j);
                check($sformatf("%s_data%0d", vecs[v].name, j), got_q[j].data, vecs[v].w[j]);
            end
        end

        // Held-valid timing: write strobe the cycle after byte 4, one stall per word.
        do_reset();
        stall_cnt = 0;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        check("bp_we0", bus.imem_we, 1);
        check("bp_addr0", bus.imem_addr, 0);
        check("bp_wdata0", bus.imem_wdata, 32'hDEADBEEF);
        check("bp_ready_low", bus.in_ready, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        check("bp_we1", bus.imem_we, 1);
        check("bp_addr1", bus.imem_addr, 1);
        check("bp_wdata1", bus.imem_wdata, 32'h00000001);
        check("bp_done_early", load_done, 0);
        send_byte(8'h23, 0);
        check("bp_load_done", load_done, 1);
        check("bp_cpu_run", cpu_run, 1);
        check("bp_stalls", stall_cnt, 2);

        // Full-depth load of 256 words.
        do_reset();
        got_q.delete();
        stream_q.delete();
        stream_q.push_back(8'hA5); stream_q.push_back(8'h01); stream_q.push_back(8'h00);
        rb = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            stream_q.push_back(8'($urandom));
            rb ^= stream_q[$];
        end
        stream_q.push_back(rb);
        st = ref_model();
        send_stream(0);
        check_status("full", st);
        idle(2);
        compare_writes("full");
        if (got_q.size() > 0) check("full_last_addr", got_q[$].addr, 255);

        // Reset after the 6th payload byte aborts; a fresh frame then loads.
        do_reset();
        got_q.delete();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0);
        send_byte(8'hEF, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("abort_pre_writes", got_q.size(), 1);
        do_reset();
        idle(5);
        check("abort_post_writes", got_q.size(), 1);
        send_nominal();
        check("abort_reload_done", load_done, 1);
        idle(2);
        check("abort_reload_writes", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("abort_reload_w0", got_q[1], {8'h00, 32'hDEADBEEF});
            check("abort_reload_w1", got_q[2], {8'h01, 32'h00000001});
        end

        // Reload from DONE: junk keeps the CPU running, SYNC stops it.
        do_reset();
        send_nominal();
        check("reload_run0", cpu_run, 1);
        send_byte(8'h00, 0);
        check("reload_junk_run", cpu_run, 1);
        send_byte(8'hA5, 0);
        check("reload_sync_run", cpu_run, 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
        send_byte(8'h08, 0);
        check("reload_run1", cpu_run, 1);
        check("reload_done1", load_done, 1);

        // Random frame streams with junk, gaps, bad lengths and bad checksums.
        for (int r = 0; r < 6; r++) begin
            int nf;
            int kind;
            int n;
            do_reset();
            got_q.delete();
            stream_q.delete();
            nf = $urandom_range(2, 5);
            for (int f = 0; f < nf; f++) begin
                repeat ($urandom_range(0, 2)) begin
                    rb = 8'($urandom);
                    stream_q.push_back((rb == 8'hA5) ? 8'h5A : rb);
                end
                kind = $urandom_range(0, 9);
                stream_q.push_back(8'hA5);
                if (kind == 0) begin
                    stream_q.push_back(8'h00); stream_q.push_back(8'h00);
                end else if (kind == 1) begin
                    stream_q.push_back(8'h01); stream_q.push_back(8'h2C);
                end else begin
                    n = $urandom_range(1, 6);
                    stream_q.push_back(8'h00); stream_q.push_back(8'(n));
                    rb = 8'h00;
                    for (int i = 0; i < 4 * n; i++) begin
                        stream_q.push_back(8'($urandom));
                        rb ^= stream_q[$];
                    end
                    if (kind == 2) rb ^= 8'(1 << $urandom_range(0, 7));
                    stream_q.push_back(rb);
                end
            end
            st = ref_model();
            send_stream(2);
            idle(3);
            check_status($sformatf("rand%0d", r), st);
            compare_writes($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
